// File: rtl/parity_pkg.sv
// parity_pkg: shared constants and output-stage state type for the parity arbiter
package parity_pkg;
  localparam int PARITY_CNT_W = 16;
  typedef enum logic {ST_EMPTY, ST_FULL} state_t;
endpackage

// File: rtl/parity_calc.sv
// parity_calc: combinational even/odd parity of one word
module parity_calc #(
  parameter int N_BITS = 6
) (
  input  logic [N_BITS-1:0] data_i,
  output logic              even_o,
  output logic              odd_o
);
  assign even_o = ^data_i;
  assign odd_o  = ~even_o;
endmodule

// File: rtl/parity_gen_arbiter.sv
// parity_gen_arbiter: round-robin share of one parity generator with a registered valid/ready output
// Optional odd-word statistics counter enabled by PARITY_STATS_EN.
module parity_gen_arbiter
  import parity_pkg::*;
#(
  parameter  int N_BITS = 6,
  parameter  int N_REQ  = 4,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*N_BITS-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_BITS-1:0]       out_data,
  output logic [ID_W-1:0]         out_id,
  output logic                    out_even_parity,
  output logic                    out_odd_parity
`ifdef PARITY_STATS_EN
  ,
  input  logic                    stats_clr,
  output logic [PARITY_CNT_W-1:0] odd_word_cnt
`endif
);
  state_t              state_q;
  logic [N_BITS-1:0]   data_q;
  logic [ID_W-1:0]     id_q, rr_q, rr_d, win;
  logic                even_q, odd_q, grant, take, can_accept, even_w, odd_w;
  logic [N_BITS-1:0]   word;
  // Scan from the highest offset down so the nearest request at/after rr_q wins.
  always_comb begin
    grant = 1'b0;
    win   = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(rr_q) + k) % N_REQ]) begin
        grant = 1'b1;
        win   = ID_W'((int'(rr_q) + k) % N_REQ);
      end
  end
  assign can_accept = (state_q == ST_EMPTY) || out_ready;
  assign take       = can_accept && grant;
  assign req_ready  = take ? (N_REQ'(1) << win) : '0;
  assign word       = req_data[int'(win)*N_BITS +: N_BITS];
  assign rr_d       = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
  parity_calc #(.N_BITS(N_BITS)) u_calc (
    .data_i(word),
    .even_o(even_w),
    .odd_o (odd_w)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      even_q  <= 1'b0;
      odd_q   <= 1'b1;
      rr_q    <= '0;
    end else if (take) begin
      state_q <= ST_FULL;
      data_q  <= word;
      id_q    <= win;
      even_q  <= even_w;
      odd_q   <= odd_w;
      rr_q    <= rr_d;
    end else if (out_ready) begin
      state_q <= ST_EMPTY;
    end
  end
  assign out_valid       = (state_q == ST_FULL);
  assign out_data        = data_q;
  assign out_id          = id_q;
  assign out_even_parity = even_q;
  assign out_odd_parity  = odd_q;
`ifdef PARITY_STATS_EN
  logic [PARITY_CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = stats_clr ? '0 :
                 (out_valid && out_ready && even_q && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign odd_word_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_parity_gen_arbiter.sv
// tb_parity_gen_arbiter: directed + random stimulus checked against a behavioural model
module tb_parity_gen_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [23:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        out_valid, out_ready = 1'b0;
  logic [5:0]  out_data;
  logic [1:0]  out_id;
  logic        out_even_parity, out_odd_parity;
  logic        stats_clr = 1'b0;
`ifdef PARITY_STATS_EN
  logic [15:0] odd_word_cnt;
`endif

  parity_gen_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .out_even_parity(out_even_parity), .out_odd_parity(out_odd_parity)
`ifdef PARITY_STATS_EN
    , .stats_clr(stats_clr), .odd_word_cnt(odd_word_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int         m_ptr = 0;
  bit         m_valid = 0;
  logic [5:0] m_data = '0;
  int         m_id = 0;
  bit         m_even = 0;
  int         m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v);
    for (int k = 0; k < 4; k++)
      if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  // One clock: drive inputs, check handshake, advance model at the edge, check outputs.
  task automatic cycle(input logic [3:0] v, input logic [23:0] d, input logic rdy, input logic r);
    int w;
    bit acc;
    req_valid = v; req_data = d; out_ready = rdy; rst = r;
    #1;
    w = pick(v);
    acc = !m_valid || rdy;
    if (!r) chk("req_ready", {28'b0, req_ready}, (acc && w >= 0) ? (32'd1 << w) : 32'd0);
    @(posedge clk);
    if (r) begin
      m_ptr = 0; m_valid = 0; m_data = '0; m_id = 0; m_even = 0; m_cnt = 0;
    end else begin
      if (stats_clr) m_cnt = 0;
      else if (m_valid && rdy && m_even && m_cnt < 65535) m_cnt++;
      if (acc && w >= 0) begin
        m_data = d[w*6 +: 6]; m_id = w; m_even = ($countones(m_data) % 2) == 1;
        m_ptr = (w + 1) % 4; m_valid = 1;
      end else if (rdy) m_valid = 0;
    end
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    chk("out_data", {26'b0, out_data}, {26'b0, m_data});
    chk("out_id", {30'b0, out_id}, m_id);
    chk("out_even", {31'b0, out_even_parity}, {31'b0, m_even});
    chk("out_odd", {31'b0, out_odd_parity}, {31'b0, !m_even});
`ifdef PARITY_STATS_EN
    chk("odd_word_cnt", {16'b0, odd_word_cnt}, m_cnt);
`endif
  endtask

  initial begin
    logic [23:0] rd;
    // Reset
    cycle(4'b0000, '0, 1'b1, 1'b1);
    cycle(4'b0000, '0, 1'b1, 1'b1);
    chk("rst_odd", {31'b0, out_odd_parity}, 32'd1);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    // Single requester 2 with 101101
    cycle(4'b0100, {6'd0, 6'b101101, 12'd0}, 1'b1, 1'b0);
    chk("single_data", {26'b0, out_data}, 32'b101101);
    chk("single_id", {30'b0, out_id}, 32'd2);
    chk("single_even", {31'b0, out_even_parity}, 32'd0);
    cycle(4'b0000, '0, 1'b1, 1'b0);
    // Wrap fairness: rr now 3, requesters 0 and 3 -> 3 then 0
    cycle(4'b1001, {6'h3c, 6'h0, 6'h0, 6'h01}, 1'b1, 1'b0);
    chk("wrap_first", {30'b0, out_id}, 32'd3);
    cycle(4'b1001, {6'h3c, 6'h0, 6'h0, 6'h01}, 1'b1, 1'b0);
    chk("wrap_second", {30'b0, out_id}, 32'd0);
    // All four valid, back-to-back
    for (int i = 0; i < 8; i++) begin
      rd = $urandom;
      cycle(4'b1111, rd, 1'b1, 1'b0);
      chk("rr_seq", {30'b0, out_id}, (i + 1) % 4);
    end
    // Backpressure for 5 cycles then release
    for (int i = 0; i < 5; i++) cycle(4'b1111, $urandom, 1'b0, 1'b0);
    cycle(4'b1111, 24'hffffff, 1'b1, 1'b0);
    chk("ones_even", {31'b0, out_even_parity}, 32'd0);
    // Mid-traffic reset drops held word, pointer returns to 0
    cycle(4'b0010, $urandom, 1'b0, 1'b0);
    cycle(4'b1111, $urandom, 1'b0, 1'b1);
    cycle(4'b1111, $urandom, 1'b0, 1'b1);
    chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    cycle(4'b1111, $urandom, 1'b1, 1'b0);
    chk("rst_ptr_id", {30'b0, out_id}, 32'd0);
`ifdef PARITY_STATS_EN
    stats_clr = 1'b1;
    cycle(4'b0000, '0, 1'b1, 1'b0);
    stats_clr = 1'b0;
    for (int i = 0; i < 3; i++) cycle(4'b0001, 24'h000001, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cycle(4'b0001, 24'h000003, 1'b1, 1'b0);
    cycle(4'b0000, '0, 1'b1, 1'b0);
    chk("stats_three", {16'b0, odd_word_cnt}, 32'd3);
    cycle(4'b0001, 24'h000001, 1'b1, 1'b0);
    stats_clr = 1'b1;
    cycle(4'b0000, '0, 1'b1, 1'b0);
    stats_clr = 1'b0;
    chk("stats_clr", {16'b0, odd_word_cnt}, 32'd0);
`endif
    // Random traffic
    for (int i = 0; i < 400; i++) begin
`ifdef PARITY_STATS_EN
      stats_clr = ($urandom % 16) == 0;
`endif
      cycle(4'($urandom), 24'($urandom), ($urandom % 4) != 0, ($urandom % 64) == 0);
    end
    stats_clr = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
